// File: rtl/wb2sci_multi_bridge.sv
// Wishbone slave to SCI master bridge: decodes layer/neuron/register fields into a
// one-hot active-low chip select and runs read, write or read-modify-write phases.
module wb2sci_multi_bridge #(
  parameter int ADDR_WIDTH        = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int NUM_LAYERS        = 4,
  parameter int NEURONS_PER_LAYER = 16,
  parameter int REG_FIELD         = 8,
  parameter int NEURON_FIELD      = 7,
  parameter int LAYER_FIELD       = 2,
  parameter int SCI_ADDR_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                                    CLK,
  input  logic                                    RST,
  input  logic                                    WB_CYC,
  input  logic                                    WB_STB,
  input  logic                                    WB_WE,
  input  logic [ADDR_WIDTH-1:0]                   WB_ADDR,
  input  logic [DATA_WIDTH-1:0]                   WB_WDATA,
  input  logic [DATA_WIDTH/8-1:0]                 WB_SEL,
  output logic                                    WB_STALL,
  output logic                                    WB_ACK,
  output logic                                    WB_ERR,
  output logic [DATA_WIDTH-1:0]                   WB_RDATA,
  output logic                                    SCI_REQ,
  output logic                                    SCI_WNR,
  output logic [SCI_ADDR_WIDTH-1:0]               SCI_ADDR,
  output logic [NUM_LAYERS*NEURONS_PER_LAYER-1:0] SCI_CSN,
  output logic [DATA_WIDTH-1:0]                   SCI_WDATA,
  input  logic                                    SCI_ACK,
  input  logic [DATA_WIDTH-1:0]                   SCI_RDATA,
  output logic [7:0]                              TIMEOUT_COUNT
);

  localparam int CS_W     = NUM_LAYERS * NEURONS_PER_LAYER;
  localparam int CS_IDX_W = (CS_W > 1) ? $clog2(CS_W) : 1;
  localparam int SEL_W    = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCI_RD,
    S_SCI_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_t;

  state_t                    state_q, state_d;
  logic                      req_q, req_d;
  logic                      wnr_q, wnr_d;
  logic [SCI_ADDR_WIDTH-1:0] sci_addr_q, sci_addr_d;
  logic [DATA_WIDTH-1:0]     sci_wdata_q, sci_wdata_d;
  logic [CS_W-1:0]           csn_q, csn_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [7:0]                tocnt_q, tocnt_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  logic [DATA_WIDTH-1:0]     wdat_q, wdat_d;

  logic [NEURON_FIELD-1:0]   dec_neuron;
  logic [LAYER_FIELD-1:0]    dec_layer;
  logic                      dec_valid;
  logic [CS_IDX_W-1:0]       dec_idx;
  logic [CS_W-1:0]           dec_csn;
  logic [DATA_WIDTH-1:0]     merge;
  logic                      limit_hit;
  logic                      unused_addr;

  assign dec_neuron  = WB_ADDR[REG_FIELD +: NEURON_FIELD];
  assign dec_layer   = WB_ADDR[REG_FIELD+NEURON_FIELD +: LAYER_FIELD];
  assign dec_valid   = (32'(dec_layer) < 32'(NUM_LAYERS)) &&
                       (32'(dec_neuron) < 32'(NEURONS_PER_LAYER));
  assign dec_idx     = CS_IDX_W'(32'(dec_layer) * 32'(NEURONS_PER_LAYER) + 32'(dec_neuron));
  assign unused_addr = ^WB_ADDR;
  // The phase that is running now is its TIMEOUT_CYCLES-th cycle.
  assign limit_hit   = ({1'b0, cnt_q} + 17'd1) >= 17'(TIMEOUT_CYCLES);

  always_comb begin
    dec_csn = '1;
    dec_csn[dec_idx] = 1'b0;
  end

  always_comb begin
    merge = SCI_RDATA;
    for (int b = 0; b < SEL_W; b++) begin
      if (sel_q[b]) merge[8*b +: 8] = wdat_q[8*b +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = 1'b0;
    wnr_d       = wnr_q;
    sci_addr_d  = sci_addr_q;
    sci_wdata_d = sci_wdata_q;
    csn_d       = csn_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    tocnt_d     = tocnt_q;
    sel_d       = sel_q;
    wdat_d      = wdat_q;
    case (state_q)
      S_IDLE: begin
        if (WB_CYC && WB_STB) begin
          sel_d  = WB_SEL;
          wdat_d = WB_WDATA;
          err_d  = 1'b0;
          cnt_d  = '0;
          if (!dec_valid) begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end else if (WB_WE && (WB_SEL == '0)) begin
            state_d = S_RESP;
          end else begin
            req_d       = 1'b1;
            csn_d       = dec_csn;
            sci_addr_d  = WB_ADDR[SCI_ADDR_WIDTH-1:0];
            sci_wdata_d = WB_WDATA;
            wnr_d       = WB_WE && (&WB_SEL);
            if (!WB_WE)       state_d = S_SCI_RD;
            else if (&WB_SEL) state_d = S_SCI_WR;
            else              state_d = S_RMW_RD;
          end
        end
      end
      S_SCI_RD, S_SCI_WR, S_RMW_RD, S_RMW_WR: begin
        // An acknowledge on the limit cycle still completes the phase.
        if (SCI_ACK) begin
          if (state_q == S_RMW_RD) begin
            state_d     = S_RMW_WR;
            req_d       = 1'b1;
            wnr_d       = 1'b1;
            sci_wdata_d = merge;
            cnt_d       = '0;
          end else begin
            if (state_q == S_SCI_RD) rdata_d = SCI_RDATA;
            state_d = S_RESP;
            csn_d   = '1;
          end
        end else if (limit_hit) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          csn_d   = '1;
          tocnt_d = (tocnt_q == 8'hFF) ? tocnt_q : tocnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        csn_d   = '1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      wnr_q       <= 1'b0;
      sci_addr_q  <= '0;
      sci_wdata_q <= '0;
      csn_q       <= '1;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      tocnt_q     <= '0;
      sel_q       <= '0;
      wdat_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      wnr_q       <= wnr_d;
      sci_addr_q  <= sci_addr_d;
      sci_wdata_q <= sci_wdata_d;
      csn_q       <= csn_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      tocnt_q     <= tocnt_d;
      sel_q       <= sel_d;
      wdat_q      <= wdat_d;
    end
  end

  assign WB_STALL      = (state_q != S_IDLE);
  assign WB_ACK        = (state_q == S_RESP) && !err_q && WB_CYC;
  assign WB_ERR        = (state_q == S_RESP) && err_q && WB_CYC;
  assign WB_RDATA      = rdata_q;
  assign SCI_REQ       = req_q;
  assign SCI_WNR       = wnr_q;
  assign SCI_ADDR      = sci_addr_q;
  assign SCI_CSN       = csn_q;
  assign SCI_WDATA     = sci_wdata_q;
  assign TIMEOUT_COUNT = tocnt_q;

endmodule
